// File: rtl/fc_layer_seq_if.sv
// Handshake and configuration bundle for fc_layer_seq.
//   in_valid/in_ready/in_data   : input activation vector (element i at [i*DATA_W +: DATA_W])
//   cfg_shift/cfg_relu_en       : requantisation shift and ReLU enable, latched with the input
//   w_wr_*/b_wr_*               : weight (addr = o*IN_SIZE + i) and bias write ports
//   out_valid/out_ready/out_data: result vector (neuron o at [o*DATA_W +: DATA_W])
//   busy                        : engine is not idle
// master = producer/consumer side (drives inputs), slave = the layer itself.
interface fc_layer_seq_if #(
  parameter int IN_SIZE  = 64,
  parameter int OUT_SIZE = 16,
  parameter int DATA_W   = 8,
  parameter int SHIFT_W  = 5
);
  localparam int WA_W = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1;
  localparam int BA_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [IN_SIZE*DATA_W-1:0]    in_data;
  logic [SHIFT_W-1:0]           cfg_shift;
  logic                         cfg_relu_en;
  logic                         w_wr_en;
  logic [WA_W-1:0]              w_wr_addr;
  logic [DATA_W-1:0]            w_wr_data;
  logic                         b_wr_en;
  logic [BA_W-1:0]              b_wr_addr;
  logic [DATA_W-1:0]            b_wr_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_SIZE*DATA_W-1:0]   out_data;
  logic                         busy;

  modport master (
    output in_valid, in_data, cfg_shift, cfg_relu_en,
    output w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_addr, b_wr_data,
    output out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, cfg_shift, cfg_relu_en,
    input  w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_addr, b_wr_data,
    input  out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer. LANES neurons are computed in parallel and
// time-multiplexed over OUT_SIZE/LANES groups; each group takes IN_SIZE MAC
// cycles plus one post-processing cycle (shift, optional ReLU, saturate).
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : fc_layer_seq_if.slave (input vector, config, weight/bias
//                write ports, result vector, busy)
// Weight/bias memories are only writable while idle and are never reset.
module fc_layer_seq #(
  parameter int IN_SIZE  = 64,
  parameter int OUT_SIZE = 16,
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SHIFT_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  fc_layer_seq_if.slave  bus
);

  localparam int G     = OUT_SIZE / LANES;
  localparam int IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int GRP_W = (G > 1) ? $clog2(G) : 1;
  localparam int WA_W  = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1;
  localparam int BA_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int PW    = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_POST, S_OUT} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [GRP_W-1:0]            grp_q, grp_d;
  logic [OUT_SIZE*DATA_W-1:0]  out_data_q, out_data_d;

  logic signed [DATA_W-1:0]    x_q [IN_SIZE];
  logic signed [DATA_W-1:0]    x_d [IN_SIZE];
  logic [SHIFT_W-1:0]          shift_q, shift_d;
  logic                        relu_q, relu_d;
  logic signed [ACC_W-1:0]     acc_q [LANES];
  logic signed [ACC_W-1:0]     acc_d [LANES];

  logic signed [DATA_W-1:0]    w_mem [OUT_SIZE*IN_SIZE];
  logic signed [DATA_W-1:0]    b_mem [OUT_SIZE];

  logic signed [PW-1:0]        lane_prod [LANES];
  logic signed [ACC_W-1:0]     lane_bias [LANES];

  // Arithmetic right shift (truncating toward -inf) then optional ReLU clamp.
  function automatic logic signed [ACC_W-1:0] requant(
    input logic signed [ACC_W-1:0] acc,
    input logic [SHIFT_W-1:0]      sh,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] v;
    v = acc >>> sh;
    if (relu && v[ACC_W-1]) v = '0;
    return v;
  endfunction

  // Clamp to the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  // Memory writes are gated by IDLE so an in-flight result never sees a
  // partially updated weight set.
  always_ff @(posedge clk) begin
    if (bus.w_wr_en && (state_q == S_IDLE)) w_mem[bus.w_wr_addr] <= bus.w_wr_data;
    if (bus.b_wr_en && (state_q == S_IDLE)) b_mem[bus.b_wr_addr] <= bus.b_wr_data;
  end

  // Per-lane operand fetch: lane l of group g serves neuron g*LANES + l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WA_W-1:0] w_addr;
    logic [BA_W-1:0] b_addr;
    assign b_addr       = BA_W'(int'(grp_q) * LANES + l);
    assign w_addr       = WA_W'((int'(grp_q) * LANES + l) * IN_SIZE + int'(idx_q));
    assign lane_prod[l] = PW'(w_mem[w_addr]) * PW'(x_q[idx_q]);
    assign lane_bias[l] = ACC_W'(b_mem[b_addr]);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    grp_d      = grp_q;
    out_data_d = out_data_q;
    x_d        = x_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    acc_d      = acc_q;

    unique case (state_q)
      // ---- IDLE: capture input vector and configuration on handshake
      S_IDLE: begin
        if (bus.in_valid) begin
          for (int i = 0; i < IN_SIZE; i++) x_d[i] = bus.in_data[i*DATA_W +: DATA_W];
          shift_d = bus.cfg_shift;
          relu_d  = bus.cfg_relu_en;
          idx_d   = '0;
          grp_d   = '0;
          state_d = S_MAC;
        end
      end
      // ---- MAC: one input element per cycle; bias folded into the first term
      S_MAC: begin
        for (int l = 0; l < LANES; l++) begin
          if (idx_q == '0) acc_d[l] = lane_bias[l] + ACC_W'(lane_prod[l]);
          else             acc_d[l] = acc_q[l]    + ACC_W'(lane_prod[l]);
        end
        if (idx_q == IDX_W'(IN_SIZE - 1)) state_d = S_POST;
        else                               idx_d   = idx_q + IDX_W'(1);
      end
      // ---- POST: requantise the group and store into its output slots
      S_POST: begin
        for (int l = 0; l < LANES; l++) begin
          out_data_d[(int'(grp_q) * LANES + l) * DATA_W +: DATA_W] =
            sat(requant(acc_q[l], shift_q, relu_q));
        end
        if (grp_q == GRP_W'(G - 1)) begin
          state_d = S_OUT;
        end else begin
          grp_d   = grp_q + GRP_W'(1);
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      // ---- OUT: hold result until the consumer accepts it
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      grp_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      grp_q      <= grp_d;
      out_data_q <= out_data_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    x_q     <= x_d;
    shift_q <= shift_d;
    relu_q  <= relu_d;
    acc_q   <= acc_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: directed scenarios plus randomised
// vectors, checked against an arithmetic reference model of the layer.
module tb_fc_layer_seq;
  localparam int IN_SIZE  = 4;
  localparam int OUT_SIZE = 4;
  localparam int LANES    = 2;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 20;
  localparam int SHIFT_W  = 5;
  localparam int LAT      = (OUT_SIZE / LANES) * (IN_SIZE + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_layer_seq_if #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .DATA_W(DATA_W),
                    .SHIFT_W(SHIFT_W)) bus ();

  fc_layer_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .LANES(LANES),
                 .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int wm [OUT_SIZE*IN_SIZE];
  int bm [OUT_SIZE];
  int xv [IN_SIZE];
  int exp_o [OUT_SIZE];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // Reference: y[o] = sat(relu((bias[o] + sum_i w[o][i]*x[i]) >>> shift))
  function automatic void model(input int sh, input bit relu);
    for (int o = 0; o < OUT_SIZE; o++) begin
      int acc;
      int v;
      acc = bm[o];
      for (int i = 0; i < IN_SIZE; i++) acc += wm[o*IN_SIZE + i] * xv[i];
      acc = acc & ((1 << ACC_W) - 1);
      if (acc >= (1 << (ACC_W - 1))) acc -= (1 << ACC_W);
      v = acc >>> sh;
      if (relu && v < 0) v = 0;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      exp_o[o] = v;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) begin
      bus.w_wr_en   = 1'b1;
      bus.w_wr_addr = 4'(k);
      bus.w_wr_data = wm[k][7:0];
      bus.b_wr_en   = (k < OUT_SIZE);
      bus.b_wr_addr = 2'(k);
      bus.b_wr_data = bm[k % OUT_SIZE][7:0];
      tick();
    end
    bus.w_wr_en = 1'b0;
    bus.b_wr_en = 1'b0;
  endtask

  // Handshake, then scramble the inputs to show they were latched.
  task automatic start(input int sh, input bit relu);
    for (int i = 0; i < IN_SIZE; i++) bus.in_data[i*DATA_W +: DATA_W] = xv[i][7:0];
    bus.cfg_shift   = 5'(sh);
    bus.cfg_relu_en = relu;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid    = 1'b0;
    bus.in_data     = $urandom();
    bus.cfg_shift   = 5'($urandom());
    bus.cfg_relu_en = ~relu;
  endtask

  task automatic wait_out(input string tag, input bit chk_lat);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    chk({tag, "_valid_seen"}, 32'(bus.out_valid), 32'd1);
    if (chk_lat) chk({tag, "_latency"}, cnt, LAT);
  endtask

  task automatic chk_out(input string tag);
    for (int o = 0; o < OUT_SIZE; o++)
      chk($sformatf("%s_out%0d", tag, o), 32'(bus.out_data[o*DATA_W +: DATA_W]),
          32'(exp_o[o][7:0]));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input int sh, input bit relu);
    model(sh, relu);
    start(sh, relu);
    wait_out(tag, 1'b1);
    chk_out(tag);
    drain(tag);
  endtask

  task automatic set_basic();
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) wm[k] = 1;
    for (int o = 0; o < OUT_SIZE; o++) bm[o] = 0;
    for (int i = 0; i < IN_SIZE; i++) xv[i] = i + 1;
  endtask

  initial begin
    logic [31:0] expv;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.cfg_shift = '0;  bus.cfg_relu_en = 1'b0;
    bus.w_wr_en = 1'b0;   bus.w_wr_addr = '0; bus.w_wr_data = '0;
    bus.b_wr_en = 1'b0;   bus.b_wr_addr = '0; bus.b_wr_data = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_data",  bus.out_data,       32'd0);

    // Scenario 1: all-ones weights
    set_basic();
    load_all();
    run("s1", 0, 1'b0);
    chk("s1_literal", 32'(bus.out_data[7:0]), 32'h0A);

    // Scenario 2: negative weights, one nonzero bias, with and without ReLU
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) wm[k] = -1;
    bm[2] = 5;
    load_all();
    run("s2", 0, 1'b0);
    chk("s2_literal", 32'(bus.out_data[23:16]), 32'hFB);
    run("s2r", 0, 1'b1);

    // Scenario 3: saturation and large shift
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) wm[k] = 127;
    for (int o = 0; o < OUT_SIZE; o++) bm[o] = 0;
    for (int i = 0; i < IN_SIZE; i++) xv[i] = 127;
    load_all();
    run("s3a", 0, 1'b0);
    chk("s3a_literal", 32'(bus.out_data[7:0]), 32'h7F);
    run("s3b", 9, 1'b0);
    chk("s3b_literal", 32'(bus.out_data[7:0]), 32'd126);
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) wm[k] = -128;
    load_all();
    run("s3c", 0, 1'b0);
    chk("s3c_literal", 32'(bus.out_data[7:0]), 32'h80);

    // Scenario 4: back-pressure with a pending input
    set_basic();
    load_all();
    model(0, 1'b0);
    start(0, 1'b0);
    wait_out("s4", 1'b1);
    for (int o = 0; o < OUT_SIZE; o++) expv[o*8 +: 8] = exp_o[o][7:0];
    for (int i = 0; i < IN_SIZE; i++) bus.in_data[i*DATA_W +: DATA_W] = xv[i][7:0];
    bus.cfg_shift = '0;
    bus.cfg_relu_en = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("s4_hold_data",  bus.out_data,           expv);
      chk("s4_hold_ready", 32'(bus.in_ready),      32'd0);
      chk("s4_hold_valid", 32'(bus.out_valid),     32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("s4_rel_valid", 32'(bus.out_valid), 32'd0);
    chk("s4_rel_ready", 32'(bus.in_ready),  32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("s4_accept_busy",  32'(bus.busy),     32'd1);
    chk("s4_accept_ready", 32'(bus.in_ready), 32'd0);
    wait_out("s4b", 1'b1);
    chk_out("s4b");
    drain("s4b");

    // Scenario 5: weight write while busy is dropped; in IDLE it lands
    model(0, 1'b0);
    start(0, 1'b0);
    tick();
    bus.w_wr_en = 1'b1; bus.w_wr_addr = '0; bus.w_wr_data = 8'd50;
    tick();
    bus.w_wr_en = 1'b0;
    wait_out("s5a", 1'b0);
    chk_out("s5a");
    drain("s5a");
    wm[0] = 50;
    model(0, 1'b0);
    bus.w_wr_en = 1'b1; bus.w_wr_addr = '0; bus.w_wr_data = 8'd50;
    start(0, 1'b0);
    bus.w_wr_en = 1'b0;
    wait_out("s5b", 1'b1);
    chk_out("s5b");
    chk("s5b_literal", 32'(bus.out_data[7:0]), 32'd59);
    drain("s5b");

    // Scenario 6: reset during group 1 MAC, memories retained
    wm[0] = 1;
    load_all();
    start(0, 1'b0);
    repeat (6) tick();
    chk("s6_pre_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("s6_rst_busy",  32'(bus.busy),      32'd0);
    chk("s6_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("s6_rst_data",  bus.out_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("s6", 0, 1'b0);
    chk("s6_literal", 32'(bus.out_data[31:24]), 32'h0A);

    // Randomised vectors
    for (int t = 0; t < 8; t++) begin
      int sh;
      bit relu;
      for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) wm[k] = int'($urandom_range(0, 255)) - 128;
      for (int o = 0; o < OUT_SIZE; o++) bm[o] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < IN_SIZE; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      sh = int'($urandom_range(0, 12));
      relu = 1'($urandom_range(0, 1));
      load_all();
      run($sformatf("rnd%0d", t), sh, relu);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
